// File: rtl/trap_unit_pkg.sv
// Shared trap types: exception causes, interrupt flag bit, mtvec modes and FSM states.
// Pure declarations, no logic, no timing.
package trap_unit_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [31:0] CAUSE_ILLEGAL_INST = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT   = 32'd3;
  localparam logic [31:0] CAUSE_MISALIGNED   = 32'd4;
  localparam logic [31:0] CAUSE_ECALL_M      = 32'd11;

  localparam int INT_FLAG_BIT = 31;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

endpackage

// File: rtl/trap_unit_if.sv
// Memory-stage / CSR / fetch signals seen by the trap unit; slave = trap unit side.
// Wires only, no latency; the redirect is held until redirect_ack.
interface trap_unit_if #(
  parameter int NUM_IRQ = 4
);
  logic               mem_valid;
  logic [31:0]        mem_pc;
  logic               mem_stall;
  logic               illegal_inst;
  logic               ecall;
  logic               ebreak;
  logic               misaligned;
  logic               mret;
  logic [NUM_IRQ-1:0] irq;
  logic               mie_global;
  logic [NUM_IRQ-1:0] mie_mask;
  logic [31:0]        mtvec_base;
  logic [1:0]         mtvec_mode;
  logic [31:0]        mepc_in;
  logic               redirect_ack;
  logic               trap_req;
  logic               mret_req;
  logic [31:0]        trap_pc;
  logic [31:0]        trap_cause;
  logic [31:0]        trap_target;
  logic               is_interrupt;
  logic               f2d_flush;
  logic               d2e_flush;
  logic               e2m_flush;
  logic               m2w_flush;
  logic [NUM_IRQ-1:0] mip;
  logic               busy;

  modport master (
    output mem_valid, mem_pc, mem_stall, illegal_inst, ecall, ebreak, misaligned,
           mret, irq, mie_global, mie_mask, mtvec_base, mtvec_mode, mepc_in, redirect_ack,
    input  trap_req, mret_req, trap_pc, trap_cause, trap_target, is_interrupt,
           f2d_flush, d2e_flush, e2m_flush, m2w_flush, mip, busy
  );

  modport slave (
    input  mem_valid, mem_pc, mem_stall, illegal_inst, ecall, ebreak, misaligned,
           mret, irq, mie_global, mie_mask, mtvec_base, mtvec_mode, mepc_in, redirect_ack,
    output trap_req, mret_req, trap_pc, trap_cause, trap_target, is_interrupt,
           f2d_flush, d2e_flush, e2m_flush, m2w_flush, mip, busy
  );
endinterface

// File: rtl/trap_unit_irq_pending.sv
// Rising-edge interrupt pending bits; a new edge beats a same-cycle clear.
// One cycle from irq edge to mip; no backpressure, bits stay set until cleared.
module irq_pending #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_clr,
  output logic [NUM_IRQ-1:0] o_mip
);
  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_mip;
  logic [NUM_IRQ-1:0] w_rise;

  assign w_rise = i_irq & ~r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_mip  <= '0;
    end else begin
      r_prev <= i_irq;
      r_mip  <= (r_mip & ~i_clr) | w_rise;
    end
  end

  assign o_mip = r_mip;
endmodule

// File: rtl/trap_unit.sv
// Trap/MRET decision for the memory stage, zero latency; holds in HOLD until redirect_ack.
// TRAP_UNIT_VECTORED_EN enables vectored interrupt targets (mtvec_mode == 1).
module trap_unit #(
  parameter int NUM_IRQ        = 4,
  parameter int IRQ_CAUSE_BASE = 16
) (
  input logic        clk,
  input logic        rst,
  trap_unit_if.slave bus
);
  import trap_unit_pkg::*;

  localparam int IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  state_t             r_state;
  state_t             w_next;
  logic               w_act;
  logic               w_exc;
  logic [31:0]        w_exc_cause;
  logic [NUM_IRQ-1:0] w_mip;
  logic [NUM_IRQ-1:0] w_pend;
  logic               w_irq_hit;
  logic [IDXW-1:0]    w_irq_idx;
  logic [31:0]        w_int_cause;
  logic [31:0]        w_int_target;
  logic [NUM_IRQ-1:0] w_clr;
  logic               w_take_int;
  logic               w_trap;
  logic               w_mret;
  logic               w_flush;
  logic               w_is_int;
  logic               w_busy;
  logic [31:0]        w_cause;
  logic [31:0]        w_target;

  irq_pending #(.NUM_IRQ(NUM_IRQ)) u_pending (
    .clk   (clk),
    .rst   (rst),
    .i_irq (bus.irq),
    .i_clr (w_clr),
    .o_mip (w_mip)
  );

  assign w_act  = bus.mem_valid & ~bus.mem_stall & (r_state == ST_IDLE) & ~rst;
  assign w_exc  = bus.ebreak | bus.illegal_inst | bus.ecall | bus.misaligned;
  assign w_pend = w_mip & bus.mie_mask;

  always_comb begin
    w_exc_cause = CAUSE_MISALIGNED;
    if (bus.ebreak)            w_exc_cause = CAUSE_BREAKPOINT;
    else if (bus.illegal_inst) w_exc_cause = CAUSE_ILLEGAL_INST;
    else if (bus.ecall)        w_exc_cause = CAUSE_ECALL_M;
  end

  // Descending scan so the lowest pending index is the one left selected.
  always_comb begin
    w_irq_hit = 1'b0;
    w_irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_irq_hit = 1'b1;
        w_irq_idx = i[IDXW-1:0];
      end
    end
    w_int_cause               = 32'(IRQ_CAUSE_BASE) + 32'(w_irq_idx);
    w_int_cause[INT_FLAG_BIT] = 1'b1;
  end

`ifdef TRAP_UNIT_VECTORED_EN
  assign w_int_target = (bus.mtvec_mode == MTVEC_VECTORED)
                      ? bus.mtvec_base + {w_int_cause[29:0], 2'b00}
                      : bus.mtvec_base;
`else
  logic w_unused_mode;
  assign w_unused_mode = ^bus.mtvec_mode;
  assign w_int_target  = bus.mtvec_base;
`endif

  always_comb begin
    w_next     = r_state;
    w_trap     = 1'b0;
    w_mret     = 1'b0;
    w_is_int   = 1'b0;
    w_take_int = 1'b0;
    w_busy     = 1'b0;
    w_cause    = '0;
    w_target   = '0;
    w_clr      = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_act) begin
          if (w_exc) begin
            w_trap   = 1'b1;
            w_cause  = w_exc_cause;
            w_target = bus.mtvec_base;
          end else if (bus.mret) begin
            w_mret   = 1'b1;
            w_target = bus.mepc_in;
          end else if (bus.mie_global && w_irq_hit) begin
            w_trap     = 1'b1;
            w_is_int   = 1'b1;
            w_take_int = 1'b1;
            w_cause    = w_int_cause;
            w_target   = w_int_target;
          end
        end
        if (w_trap || w_mret) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        w_busy = ~rst;
        if (bus.redirect_ack) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_clr[i] = w_take_int && (w_irq_idx == i[IDXW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  assign w_flush          = w_trap | w_mret;
  assign bus.trap_req     = w_trap;
  assign bus.mret_req     = w_mret;
  assign bus.trap_pc      = bus.mem_pc;
  assign bus.trap_cause   = w_cause;
  assign bus.trap_target  = w_target;
  assign bus.is_interrupt = w_is_int;
  assign bus.f2d_flush    = w_flush;
  assign bus.d2e_flush    = w_flush;
  assign bus.e2m_flush    = w_flush;
  assign bus.m2w_flush    = w_flush;
  assign bus.mip          = w_mip;
  assign bus.busy         = w_busy;
endmodule

// File: doc/trap_unit.md
TRAP_UNIT -- requirements
Module: trap_unit

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of external interrupt lines (range 1..16).
REQ-002 SHALL have parameter IRQ_CAUSE_BASE, default 16, mcause code assigned to irq[0].
REQ-003 SHALL have ports, one per line, as `name  direction  width  meaning`; clock and reset are first:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_valid  input  1  valid instruction in memory stage.
- mem_pc  input  32  PC of memory-stage instruction.
- mem_stall  input  1  memory stage stalled this cycle.
- illegal_inst, ecall, ebreak, misaligned  input  1 each  synchronous exception flags for memory-stage instruction.
- mret  input  1  memory-stage instruction is MRET.
- irq  input  NUM_IRQ  external interrupt lines, level.
- mie_global  input  1  mstatus.MIE.
- mie_mask  input  NUM_IRQ  per-line enable.
- mtvec_base  input  32  trap base, word aligned.
- mtvec_mode  input  2  0 direct, 1 vectored.
- mepc_in  input  32  current mepc, for MRET.
- redirect_ack  input  1  fetch has taken the redirect.
- trap_req  output  1  trap entry pulse.
- mret_req  output  1  MRET return pulse.
- trap_pc  output  32  value for mepc.
- trap_cause  output  32  value for mcause.
- trap_target  output  32  fetch redirect address.
- is_interrupt  output  1  trap is an interrupt.
- f2d_flush, d2e_flush, e2m_flush, m2w_flush  output  1 each  pipeline register flushes.
- mip  output  NUM_IRQ  pending bits.
- busy  output  1  unit in HOLD.

Function
REQ-004 SHALL implement FSM states IDLE and HOLD.
REQ-005 SHALL, in IDLE with mem_valid=1, compute a trap decision combinationally in the same cycle, with zero latency.
REQ-006 SHALL prioritise exceptions as ebreak (cause 3), then illegal_inst (2), then ecall (11), then misaligned (4).
REQ-007 SHALL take an interrupt only when no exception and no mret is active and mie_global=1.
REQ-008 SHALL select the lowest index i with mip[i] & mie_mask[i]; its cause is 0x8000_0000 | (IRQ_CAUSE_BASE+i).
REQ-009 SHALL suppress every trap, mret_req and state change while mem_stall=1.
REQ-010 SHALL, on a trap, assert trap_req=1 and all four flushes=1, set trap_pc=mem_pc, and set trap_target per REQ-016.
REQ-011 SHALL assign priority exception > mret > interrupt.
REQ-012 SHALL, on mret, assert mret_req=1 and all four flushes, set trap_target=mepc_in, and keep trap_req=0.
REQ-013 SHALL move from IDLE to HOLD on any trap_req or mret_req.
REQ-014 SHALL, in HOLD, set busy=1, keep every request and flush at 0, and return to IDLE on the cycle redirect_ack=1.
REQ-015 SHALL keep mip[i] pending bits as follows:
- set on a 0->1 edge of irq[i], using a registered previous sample;
- clear in the cycle interrupt i is taken;
- when set and clear coincide, set wins;
- remain sticky while the unit is in HOLD.

Reset
REQ-017 SHALL, with rst=1 at a clock edge, set state=IDLE, mip=0 and the irq previous-sample register=0.
REQ-018 SHALL drive all requests, flushes and busy to 0 while rst=1.
REQ-019 SHALL treat reset during HOLD as abandoning the redirect; no ack is required afterwards.

Configuration
REQ-016 SHALL compute trap_target from macro TRAP_UNIT_VECTORED_EN:
- defined: an interrupt with mtvec_mode=1 gives mtvec_base + 4*(cause[30:0]);
- defined: exceptions, and mtvec_mode≠1, give mtvec_base;
- not defined: always mtvec_base, mtvec_mode ignored.

Structure
REQ-020 SHALL take the exception cause constants, interrupt flag bit, mtvec mode encodings and the FSM state enum from the shared common types package.
REQ-021 SHALL place pending-bit edge detection in one sub-module, irq_pending, parameterised by NUM_IRQ.

Verification
REQ-022 SHALL cover these directed scenarios:
- illegal_inst=1, mem_pc=0x100, mtvec_base=0x200 -> same cycle trap_req=1, cause=2, trap_pc=0x100, target=0x200, all flushes=1; busy=1 next cycle.
- ebreak=1 and illegal_inst=1 together -> cause=3 only.
- irq=4'b0110, mask=4'b1111, MIE=1, vectored, base=0x200 -> cause=0x8000_0011, target=0x244, mip=4'b0100 next cycle.
- irq[0] held high after being taken -> no second trap until irq[0] goes low then high again.
- mret=1, mepc_in=0x180 -> mret_req=1, target=0x180; no trap while in HOLD until redirect_ack=1.
- mem_stall=1 with illegal_inst=1 -> no trap_req; trap taken the first cycle mem_stall=0.
